// File: rtl/alu_responder.sv
// alu_responder: two-stage valid/ready ALU with yAlu opcode encoding.
// S1 holds the captured request, S2 the computed response driving rsp_*.
module alu_responder #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_a,
    input  logic [W-1:0]  req_b,
    input  logic [2:0]    req_op,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_z,
    output logic          rsp_ex,
    output logic          rsp_err,
    output logic [CW-1:0] done_count
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_a_q, s1_a_d;
    logic [W-1:0]  s1_b_q, s1_b_d;
    logic [2:0]    s1_op_q, s1_op_d;

    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s2_z_q, s2_z_d;
    logic          s2_ex_q, s2_ex_d;
    logic          s2_err_q, s2_err_d;

    logic [CW-1:0] cnt_q, cnt_d;

    logic          s2_advance;
    logic          s1_to_s2;
    logic          req_fire;
    logic          rsp_fire;

    logic [W-1:0]  alu_z;
    logic          alu_err;
    logic          alu_lt;

    always_comb begin
        s2_advance = !s2_valid_q || rsp_ready;
        s1_to_s2   = s1_valid_q && s2_advance;
        req_ready  = !s1_valid_q || s2_advance;
        req_fire   = req_valid && req_ready;
        rsp_fire   = s2_valid_q && rsp_ready;
    end

    // Signed compare stays correct when a-b would overflow.
    always_comb begin
        alu_lt  = $signed(s1_a_q) < $signed(s1_b_q);
        alu_z   = '0;
        alu_err = 1'b0;
        case (s1_op_q)
            OP_AND:  alu_z = s1_a_q & s1_b_q;
            OP_OR:   alu_z = s1_a_q | s1_b_q;
            OP_ADD:  alu_z = s1_a_q + s1_b_q;
            OP_SUB:  alu_z = s1_a_q - s1_b_q;
            OP_SLT:  alu_z = {{(W-1){1'b0}}, alu_lt};
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a;
            s1_b_d     = req_b;
            s1_op_d    = req_op;
        end else if (s1_to_s2) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_z_d     = s2_z_q;
        s2_ex_d    = s2_ex_q;
        s2_err_d   = s2_err_q;
        if (s1_to_s2) begin
            s2_valid_d = 1'b1;
            s2_z_d     = alu_z;
            s2_ex_d    = (alu_z == '0);
            s2_err_d   = alu_err;
        end else if (rsp_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rsp_fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_ex_q    <= 1'b0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_z_q     <= s2_z_d;
            s2_ex_q    <= s2_ex_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rsp_valid  = s2_valid_q;
    assign rsp_z      = s2_z_q;
    assign rsp_ex     = s2_ex_q;
    assign rsp_err    = s2_err_q;
    assign done_count = cnt_q;

endmodule

// File: tb/tb_alu_responder.sv
// Bench for alu_responder: vector table, hand-written corner sequences,
// and a queue-based reference model checking every response transfer.
module tb_alu_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic        rsp_ex;
    logic        rsp_err;
    logic [15:0] done_count;

    int n_cmp = 0;
    int n_bad = 0;

    alu_responder #(.W(32), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_ex(rsp_ex), .rsp_err(rsp_err),
        .done_count(done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected response {err, ex, z} from the opcode rules.
    function automatic logic [33:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0] op);
        logic [31:0] z;
        logic        err;
        int          sa;
        int          sb;
        sa  = a;
        sb  = b;
        z   = 32'd0;
        err = 1'b0;
        case (op)
            3'd0: z = a & b;
            3'd1: z = a | b;
            3'd2: z = a + b;
            3'd6: z = a - b;
            3'd7: z = (sa < sb) ? 32'd1 : 32'd0;
            default: err = 1'b1;
        endcase
        return {err, (z == 32'd0), z};
    endfunction

    // Monitor: at negedge the handshake signals equal those at next posedge.
    logic [33:0] exp_q[$];
    logic [15:0] cnt_m = 16'd0;
    logic        hold_pend = 1'b0;
    logic [33:0] hold_val;
    logic [33:0] e;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                cnt_m     = 16'd0;
                hold_pend = 1'b0;
            end else begin
                chk("done_count", {16'd0, done_count}, {16'd0, cnt_m});
                if (hold_pend && rsp_valid)
                    chk("rsp_stable", {rsp_err, rsp_ex, rsp_z}, hold_val);
                hold_pend = rsp_valid && !rsp_ready;
                hold_val  = {rsp_err, rsp_ex, rsp_z};
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_z", rsp_z, e[31:0]);
                        chk("rsp_ex_err", {30'd0, rsp_err, rsp_ex},
                            {30'd0, e[33], e[32]});
                    end
                    cnt_m = cnt_m + 16'd1;
                end
                if (req_valid && req_ready)
                    exp_q.push_back(model(req_a, req_b, req_op));
            end
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] z;
        logic        ex;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        step();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_z", rsp_z, 32'd0);
        chk("rst_ex_err", {30'd0, rsp_ex, rsp_err}, 32'd0);
        chk("rst_done", {16'd0, done_count}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic drain();
        int guard;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        guard = 0;
        while ((rsp_valid || exp_q.size() != 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("drain_timeout", guard, (guard < 20) ? guard : 0);
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        vecs.push_back('{32'd5, 32'd3, 3'b010, 32'd8, 1'b0, 1'b0});
        vecs.push_back('{32'd7, 32'd7, 3'b110, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0});
        vecs.push_back('{32'd1, 32'h80000000, 3'b111, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 3'b101, 32'd0, 1'b1, 1'b1});
        vecs.push_back('{32'h0000F0F0, 32'h00000FF0, 3'b000, 32'h000000F0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000F000, 32'h0000000F, 3'b001, 32'h0000F00F, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{32'd0, 32'd1, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'd0, 3'b111, 32'd1, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{32'd3, 32'd4, 3'b011, 32'd0, 1'b1, 1'b1});
        vecs.push_back('{32'd1, 32'd2, 3'b100, 32'd0, 1'b1, 1'b1});

        step();
        mon_en = 1'b1;
        do_reset();

        // Single requests with latency checks.
        foreach (vecs[i]) begin
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            req_op    = vecs[i].op;
            req_valid = 1'b1;
            #1;
            chk("vec_req_ready", {31'd0, req_ready}, 32'd1);
            step();
            req_valid = 1'b0;
            chk("vec_lat1_valid", {31'd0, rsp_valid}, 32'd0);
            step();
            chk("vec_lat2_valid", {31'd0, rsp_valid}, 32'd1);
            chk("vec_z", rsp_z, vecs[i].z);
            chk("vec_ex_err", {30'd0, rsp_ex, rsp_err},
                {30'd0, vecs[i].ex, vecs[i].err});
            step();
            chk("vec_done", {16'd0, done_count}, i + 1);
        end

        // Backpressure: two accepted, third stalled, then release.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_a  = 32'd100 + k;
            req_b  = 32'd10;
            req_op = 3'b010;
            #1;
            chk("bp_req_ready", {31'd0, req_ready}, (k < 2) ? 32'd1 : 32'd0);
            if (k < 2) step();
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_held_z", rsp_z, 32'd110);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("bp_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_rsp2_z", rsp_z, 32'd111);
        step();
        chk("bp_rsp3_z", rsp_z, 32'd112);
        step();
        chk("bp_empty", {31'd0, rsp_valid}, 32'd0);
        chk("bp_done", {16'd0, done_count}, 32'd3);

        // Streaming 10 random pairs per legal opcode, full throughput.
        begin
            logic [2:0] ops[5];
            ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
            rsp_ready = 1'b1;
            req_valid = 1'b1;
            for (int k = 0; k < 50; k++) begin
                req_a  = $urandom;
                req_b  = (k % 4 == 0) ? req_a : $urandom;
                req_op = ops[k / 10];
                #1;
                chk("stream_ready", {31'd0, req_ready}, 32'd1);
                if (k >= 2)
                    chk("stream_valid", {31'd0, rsp_valid}, 32'd1);
                step();
            end
            drain();
        end

        // Random traffic with random backpressure, all opcodes.
        for (int k = 0; k < 400; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_op    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: req_a = 32'h80000000;
                1: req_a = 32'h7FFFFFFF;
                default: req_a = $urandom;
            endcase
            req_b = ($urandom_range(0, 4) == 0) ? req_a : $urandom;
            step();
        end
        drain();

        // Reset with both stages full discards everything in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_a     = 32'd1;
        req_b     = 32'd2;
        req_op    = 3'b010;
        step();
        step();
        req_valid = 1'b0;
        chk("pre_rst_full", {31'd0, req_ready}, 32'd0);
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_no_stale", {31'd0, rsp_valid}, 32'd0);
        end
        chk("final_queue", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
